// File: rtl/wb_dest_queue.sv
// Write-back destination select plus in-order queue of pending register writes.
// Flags RAW hazards of the next instruction's operands against pending entries.
module wb_dest_queue #(
    parameter int IDX_W = 5,
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] ir_rt,
    input  logic [IDX_W-1:0] ir_rd,
    input  logic [IDX_W-1:0] ir_rs,
    input  logic [2:0]       reg_dst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [IDX_W-1:0] src_a,
    input  logic [IDX_W-1:0] src_b,
    output logic [IDX_W-1:0] dst_out,
    output logic             dst_valid,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic             hazard,
    output logic             sel_err
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [DEPTH-1:0][IDX_W-1:0] ent_q;
    logic [DEPTH-1:0]            vld_q;
    logic [PTR_W-1:0]            head_q, tail_q;
    logic [CNT_W-1:0]            cnt_q;
    logic                        sel_err_q;

    logic [IDX_W-1:0] sel_idx;
    logic             sel_bad;
    logic             do_push, do_pop;
    logic [DEPTH-1:0] hit;

    always_comb begin
        sel_idx = '0;
        sel_bad = 1'b0;
        case (reg_dst)
            3'b000:  sel_idx = ir_rt;
            3'b001:  sel_idx = IDX_W'(31);
            3'b010:  sel_idx = IDX_W'(29);
            3'b011:  sel_idx = ir_rd;
            3'b100:  sel_idx = ir_rs;
            default: sel_bad = 1'b1;
        endcase
    end

    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == DEPTH_C);
    assign count     = cnt_q;
    assign dst_valid = ~empty;
    assign dst_out   = empty ? '0 : ent_q[head_q];
    assign sel_err   = sel_err_q;

    // A pop in the same cycle frees the head slot, so a full queue still accepts the push.
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ent_q     <= '0;
            vld_q     <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            cnt_q     <= '0;
            sel_err_q <= 1'b0;
        end else if (flush) begin
            vld_q     <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            cnt_q     <= '0;
            sel_err_q <= 1'b0;
        end else begin
            // Pop clears before push sets, so a full push+pop on the same slot stays valid.
            if (do_pop) begin
                vld_q[head_q] <= 1'b0;
                head_q        <= head_q + PTR_W'(1);
            end
            if (do_push) begin
                ent_q[tail_q] <= sel_idx;
                vld_q[tail_q] <= 1'b1;
                tail_q        <= tail_q + PTR_W'(1);
                if (sel_bad)
                    sel_err_q <= 1'b1;
            end
            if (do_push && !do_pop)
                cnt_q <= cnt_q + CNT_W'(1);
            else if (do_pop && !do_push)
                cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_haz
        assign hit[i] = vld_q[i] &
                        (((ent_q[i] == src_a) & (src_a != '0)) |
                         ((ent_q[i] == src_b) & (src_b != '0)));
    end

    assign hazard = |hit;
endmodule

// File: doc/wb_dest_queue.md
# wb_dest_queue

Parametrised successor to the register-destination select in the multi-cycle MIPS datapath. Selects the write-back register index from the IR fields or fixed constants, and queues it in a small FIFO of pending write-backs so multi-cycle units (mult/div, loads) can retire in order. It also flags read-after-write hazards of the next instruction's operands against every pending destination. Sits between the IR/control unit and the register file write-address port.

## Interface
Parameters:
- IDX_W, 5, register index width
- DEPTH, 4, number of pending write-back entries (power of two, ≥2)
- CNT_W, 3, width of `count`; must hold DEPTH (clog2(DEPTH+1))

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- ir_rt  in  IDX_W  IR[20:16]
- ir_rd  in  IDX_W  IR[15:11]
- ir_rs  in  IDX_W  IR[25:21]
- reg_dst  in  3  destination select: 000 rt, 001 const 31, 010 const 29, 011 rd, 100 rs, 101–111 invalid
- push  in  1  enqueue selected index at tail
- pop  in  1  retire head entry (write-back done)
- flush  in  1  synchronous clear of all entries and `sel_err`
- src_a  in  IDX_W  next-instruction operand A index
- src_b  in  IDX_W  next-instruction operand B index
- dst_out  out  IDX_W  head entry index (regfile write address); 0 when empty
- dst_valid  out  1  queue non-empty
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- count  out  CNT_W  occupied entries
- hazard  out  1  src_a or src_b matches a valid pending entry
- sel_err  out  1  sticky: a push used an invalid reg_dst code

## Operation
- Select (combinational): index = rt / 31 / 29 / rd / rs per reg_dst; invalid code selects 0 and, if pushed, sets sel_err.
- Storage: circular buffer, DEPTH entries, head/tail pointers of clog2(DEPTH) bits wrapping modulo DEPTH, per-entry valid bit.
- Priority each edge: flush > (push, pop).
- flush: all valid bits cleared, pointers to 0, count 0, sel_err 0; push/pop in same cycle ignored.
- push only: accepted if not full; tail entry written, tail++, count++. Push while full (no pop) dropped, no state change, sel_err unaffected.
- pop only: accepted if not empty; head entry invalidated, head++, count--. Pop while empty ignored.
- push+pop, non-empty (including full): both accepted, count unchanged.
- push+pop, empty: push accepted, pop ignored; count becomes 1.
- hazard: OR over valid entries of (entry == src_a && src_a != 0) | (entry == src_b && src_b != 0). Index 0 ($zero) never hazards. Evaluated on registered state only; the same-cycle push is not included.
- Entries holding index 0 (invalid select or rt=0) occupy a slot and retire normally.

## Timing
- Reset (async assert, any cycle, mid-operation included): count 0, empty 1, full 0, dst_valid 0, dst_out 0, hazard 0, sel_err 0. Release synchronised by caller; first edge after release is a normal cycle.
- Push-to-visible latency: 1 cycle; entry pushed at edge N appears on dst_out after N if queue was empty, and contributes to hazard after N.
- dst_out, dst_valid, full, empty, count: derived from registers, no combinational path from push/pop.
- hazard: combinational from src_a/src_b and registered entries; one logic level of compare plus OR tree.
- sel_err: set on the edge of the offending accepted push; holds until flush or reset.

## Test plan
- Reset then push reg_dst=000 ir_rt=5, 001, 010, 011 ir_rd=12 -> after 4 pushes count=4, full=1, dst_out=5; pops yield 5, 31, 29, 12, then empty=1, dst_out=0.
- Full queue, push alone -> dropped, count stays 4; push+pop same cycle -> count 4, dst_out advances, new index at tail; wrap checked over 3×DEPTH operations.
- Pending {7, 31}, src_a=7 src_b=0 -> hazard=1; src_a=0 src_b=0 -> 0; pop 7 then src_a=7 -> 0; push of rt=0 with src_a=0 -> hazard=0.
- Push reg_dst=110 -> entry 0 queued, sel_err=1 next cycle, stays 1 across pops; flush -> sel_err=0, count=0.
- Empty queue, push+pop same cycle ir_rs=9 reg_dst=100 -> count=1, dst_out=9; pop on empty -> no change.
- Assert reset mid-stream with count=3 between edges -> all outputs to reset values immediately, before next clk edge.
